mem_access_serial_arbiter: RTL and testbench
============================================

Name: mem_access_serial_arbiter

Overview:
- N-requester front end to main memory; generalises the fixed "MSHR_NUM D-cache + 1 I-cache" scheme to parametrised requester count and outstanding depth.
- Round-robin arbitrates line-sized read/write requests onto one memory port.
- Allocates read serials and write serials from free pools, and records the owning port of each serial.
- Routes read results and write responses back to the owning requester; enforces a per-port outstanding-read cap.

Parameters:
- REQ_PORT_NUM, 3, number of requesters (≥2)
- READ_SERIAL_NUM, 8, max outstanding reads (power of 2)
- WRITE_SERIAL_NUM, 4, max outstanding writes (power of 2)
- PORT_READ_LIMIT, 4, max outstanding reads per port (1..READ_SERIAL_NUM)
- ADDR_WIDTH, 32, physical address width
- LINE_WIDTH, 128, line data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- reqValid  in  REQ_PORT_NUM  per-port request valid
- reqWE  in  REQ_PORT_NUM  1 = write
- reqAddr  in  REQ_PORT_NUM*ADDR_WIDTH  request address
- reqData  in  REQ_PORT_NUM*LINE_WIDTH  write data
- reqAck  out  REQ_PORT_NUM  one-hot accept, same cycle
- reqSerial  out  RS=log2(READ_SERIAL_NUM)  read serial of the accepted request
- reqWSerial  out  WS=log2(WRITE_SERIAL_NUM)  write serial of the accepted request
- memReqValid  out  1  request to memory
- memReqWE  out  1  write flag
- memReqAddr  out  ADDR_WIDTH  memory request address
- memReqData  out  LINE_WIDTH  memory request write data
- memReqSerial  out  RS  memory read serial
- memReqWSerial  out  WS  memory write serial
- memReqReady  in  1  memory accepts the request this cycle
- memReadValid  in  1  read result valid
- memReadSerial  in  RS  read result serial
- memReadData  in  LINE_WIDTH  read result data
- memWriteRespValid  in  1  write response valid
- memWriteRespSerial  in  WS  write response serial
- readResultValid  out  REQ_PORT_NUM  one-hot, registered
- readResultSerial  out  RS  registered read result serial
- readResultData  out  LINE_WIDTH  registered read result data
- writeRespValid  out  REQ_PORT_NUM  one-hot, registered
- writeRespSerial  out  WS  registered write response serial
- outstandingReads  out  RS+1  count of busy read serials
- protocolError  out  1  sticky error flag

Behaviour:
- Reset (asynchronous): all serials free; owner tables, per-port counters, round-robin pointer = 0; every output = 0. Reset mid-transaction drops all in-flight state. Later memory results for pre-reset serials are treated as unknown serials.
- Eligibility:
  - Read: reqValid && !reqWE && a read serial is free && portCount[p] < PORT_READ_LIMIT.
  - Write: reqValid && reqWE && a write serial is free.
- Arbitration is combinational: the first eligible port at or after rrPtr, searching cyclically.
  - memReqValid = any eligible; the memReq* fields carry the winner's request.
  - If memReqReady is high: reqAck[winner] = 1 and the serial is allocated at the clock edge.
  - If memReqReady is low: no ack and no allocation.
  - Ineligible requesters simply wait; requesters must hold a request until acked.
- Serial choice: the lowest-index free serial of the required pool. It is driven on memReqSerial/memReqWSerial and echoed on reqSerial/reqWSerial in the same cycle.
- On an accepted grant:
  - rrPtr <= winner+1 (mod REQ_PORT_NUM).
  - Read: readOwner[s] <= winner; readBusy[s] <= 1; portCount[winner]++.
  - Write: writeOwner[ws] <= winner; writeBusy[ws] <= 1.
- Read result (memReadValid):
  - Busy serial: next cycle readResultValid[readOwner[s]] = 1 with the registered serial and data; readBusy[s] <= 0; portCount[owner]--.
  - Non-busy serial: no output, protocolError <= 1.
- Write response handling mirrors read results, using writeBusy/writeOwner and writeRespValid/writeRespSerial.
- Latency: request to memory is 0 cycles; result or response to requester is exactly 1 cycle.
- Same-cycle alloc and free of the same pool: the allocation sees pre-edge busy state, so a serial freed this cycle is not reusable until the next cycle.
- Same-cycle alloc and free on one port: portCount is unchanged (increment and decrement net out).
- outstandingReads = popcount(readBusy), registered.
- Full pool (all read serials busy): no read grant, but writes remain eligible.
- protocolError is cleared only by reset.

Decomposition:
- Add to CacheSystemTypes (or a new MemAccessArbiterTypes package): REQ_PORT_NUM-derived MemReqPortIndexPath and one-hot typedefs; MemAccessSerial and MemWriteSerial redefined from READ_SERIAL_NUM and WRITE_SERIAL_NUM; a MemArbReq struct {valid, we, addr, data}.
- One sub-module, mem_access_rr_picker: cyclic priority picker taking an eligible vector and a pointer, returning a grant index and a valid flag. Instantiated once for port arbitration. Free-serial selection uses a plain priority encoder, not the round-robin picker.

Test Plan:
- Ports 0, 1, 2 all issue reads, memReqReady=1 for 3 cycles → acks to ports 0, 1, 2 in order; serials 0, 1, 2; outstandingReads=3.
- Result for serial 1 with data 0xA5.. → next cycle readResultValid=3'b010, readResultSerial=1, data 0xA5..; serial 1 reused on the next read.
- Port 0 issues 5 reads with PORT_READ_LIMIT=4 → 4 acks, then port 0 stalls while port 1 is granted; the 5th read is acked the cycle after one port-0 result.
- All 8 read serials busy while port 2 has a write pending → write acked with wserial 0; reads stay unacked.
- memReadSerial=5 never allocated → no readResultValid, protocolError=1 until reset.
- rst asserted with 3 reads outstanding → outputs 0 immediately, outstandingReads=0, first post-reset read gets serial 0.

Source files
------------

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the memory access serial arbiter, sized for the default
// 3-requester / 8-read-serial / 4-write-serial configuration.
package mem_access_arbiter_pkg;

    localparam int REQ_PORT_NUM_DEF     = 3;
    localparam int READ_SERIAL_NUM_DEF  = 8;
    localparam int WRITE_SERIAL_NUM_DEF = 4;
    localparam int PORT_READ_LIMIT_DEF  = 4;
    localparam int ADDR_WIDTH_DEF       = 32;
    localparam int LINE_WIDTH_DEF       = 128;

    typedef logic [$clog2(REQ_PORT_NUM_DEF)-1:0]     MemReqPortIndexPath;
    typedef logic [REQ_PORT_NUM_DEF-1:0]             MemReqPortOneHot;
    typedef logic [$clog2(READ_SERIAL_NUM_DEF)-1:0]  MemAccessSerial;
    typedef logic [$clog2(WRITE_SERIAL_NUM_DEF)-1:0] MemWriteSerial;

    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [LINE_WIDTH_DEF-1:0] data;
    } MemArbReq;

endpackage

// File: rtl/mem_access_serial_arbiter_rr_picker.sv
// Cyclic priority picker: first eligible index at or after i_ptr, wrapping.
module mem_access_rr_picker #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_grant,
    output logic          o_valid
);

    int w_idx;

    // Walk offsets from far to near so the nearest eligible index wins last.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (i_elig[w_idx]) begin
                o_grant = IW'(w_idx);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_serial_arbiter.sv
// N-port round-robin front end to one memory port with read/write serial
// pools, owner tracking, per-port read caps and registered result routing.
module mem_access_serial_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int REQ_PORT_NUM     = REQ_PORT_NUM_DEF,
    parameter int READ_SERIAL_NUM  = READ_SERIAL_NUM_DEF,
    parameter int WRITE_SERIAL_NUM = WRITE_SERIAL_NUM_DEF,
    parameter int PORT_READ_LIMIT  = PORT_READ_LIMIT_DEF,
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int LINE_WIDTH       = LINE_WIDTH_DEF,
    localparam int RS = $clog2(READ_SERIAL_NUM),
    localparam int WS = $clog2(WRITE_SERIAL_NUM),
    localparam int PW = $clog2(REQ_PORT_NUM),
    localparam int CW = $clog2(PORT_READ_LIMIT + 1),
    localparam int OW = RS + 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [REQ_PORT_NUM-1:0]            i_reqValid,
    input  logic [REQ_PORT_NUM-1:0]            i_reqWE,
    input  logic [REQ_PORT_NUM*ADDR_WIDTH-1:0] i_reqAddr,
    input  logic [REQ_PORT_NUM*LINE_WIDTH-1:0] i_reqData,
    output logic [REQ_PORT_NUM-1:0]            o_reqAck,
    output logic [RS-1:0]                      o_reqSerial,
    output logic [WS-1:0]                      o_reqWSerial,
    output logic                               o_memReqValid,
    output logic                               o_memReqWE,
    output logic [ADDR_WIDTH-1:0]              o_memReqAddr,
    output logic [LINE_WIDTH-1:0]              o_memReqData,
    output logic [RS-1:0]                      o_memReqSerial,
    output logic [WS-1:0]                      o_memReqWSerial,
    input  logic                               i_memReqReady,
    input  logic                               i_memReadValid,
    input  logic [RS-1:0]                      i_memReadSerial,
    input  logic [LINE_WIDTH-1:0]              i_memReadData,
    input  logic                               i_memWriteRespValid,
    input  logic [WS-1:0]                      i_memWriteRespSerial,
    output logic [REQ_PORT_NUM-1:0]            o_readResultValid,
    output logic [RS-1:0]                      o_readResultSerial,
    output logic [LINE_WIDTH-1:0]              o_readResultData,
    output logic [REQ_PORT_NUM-1:0]            o_writeRespValid,
    output logic [WS-1:0]                      o_writeRespSerial,
    output logic [OW-1:0]                      o_outstandingReads,
    output logic                               o_protocolError
);

    logic [READ_SERIAL_NUM-1:0]  r_readBusy;
    logic [PW-1:0]               r_readOwner [READ_SERIAL_NUM];
    logic [WRITE_SERIAL_NUM-1:0] r_writeBusy;
    logic [PW-1:0]               r_writeOwner [WRITE_SERIAL_NUM];
    logic [CW-1:0]               r_portCount [REQ_PORT_NUM];
    logic [PW-1:0]               r_rrPtr;
    logic [REQ_PORT_NUM-1:0]     r_readResultValid;
    logic [RS-1:0]               r_readResultSerial;
    logic [LINE_WIDTH-1:0]       r_readResultData;
    logic [REQ_PORT_NUM-1:0]     r_writeRespValid;
    logic [WS-1:0]               r_writeRespSerial;
    logic [OW-1:0]               r_outstandingReads;
    logic                        r_protocolError;

    logic                        w_live;
    logic                        w_rfree_any;
    logic [RS-1:0]               w_rfree_idx;
    logic                        w_wfree_any;
    logic [WS-1:0]               w_wfree_idx;
    logic [REQ_PORT_NUM-1:0]     w_elig;
    logic [PW-1:0]               w_win;
    logic                        w_win_vld;
    logic                        w_win_we;
    logic                        w_grant;
    logic                        w_grant_rd;
    logic                        w_grant_wr;
    logic                        w_rd_hit;
    logic [PW-1:0]               w_rd_owner;
    logic                        w_wr_hit;
    logic [PW-1:0]               w_wr_owner;
    logic [READ_SERIAL_NUM-1:0]  w_readBusy_nxt;
    logic [WRITE_SERIAL_NUM-1:0] w_writeBusy_nxt;
    logic [OW-1:0]               w_out_nxt;

    assign w_live = !i_rst;

    // Lowest-index free serial in each pool.
    always_comb begin
        w_rfree_any = 1'b0;
        w_rfree_idx = '0;
        for (int s = READ_SERIAL_NUM - 1; s >= 0; s--) begin
            if (!r_readBusy[s]) begin
                w_rfree_any = 1'b1;
                w_rfree_idx = RS'(s);
            end
        end
        w_wfree_any = 1'b0;
        w_wfree_idx = '0;
        for (int s = WRITE_SERIAL_NUM - 1; s >= 0; s--) begin
            if (!r_writeBusy[s]) begin
                w_wfree_any = 1'b1;
                w_wfree_idx = WS'(s);
            end
        end
    end

    always_comb begin
        w_elig = '0;
        for (int p = 0; p < REQ_PORT_NUM; p++) begin
            w_elig[p] = i_reqValid[p] &&
                        (i_reqWE[p] ? w_wfree_any
                                    : (w_rfree_any && (r_portCount[p] < CW'(PORT_READ_LIMIT))));
        end
    end

    mem_access_rr_picker #(.N(REQ_PORT_NUM), .IW(PW)) u_picker (
        .i_elig  (w_elig),
        .i_ptr   (r_rrPtr),
        .o_grant (w_win),
        .o_valid (w_win_vld)
    );

    assign w_win_we   = i_reqWE[w_win];
    assign w_grant    = w_win_vld && i_memReqReady && w_live;
    assign w_grant_rd = w_grant && !w_win_we;
    assign w_grant_wr = w_grant && w_win_we;

    assign w_rd_hit   = i_memReadValid && r_readBusy[i_memReadSerial];
    assign w_rd_owner = r_readOwner[i_memReadSerial];
    assign w_wr_hit   = i_memWriteRespValid && r_writeBusy[i_memWriteRespSerial];
    assign w_wr_owner = r_writeOwner[i_memWriteRespSerial];

    // Allocation uses pre-edge busy bits, so a serial freed now is reused next cycle.
    always_comb begin
        w_readBusy_nxt = r_readBusy;
        if (w_rd_hit)   w_readBusy_nxt[i_memReadSerial] = 1'b0;
        if (w_grant_rd) w_readBusy_nxt[w_rfree_idx] = 1'b1;
        w_writeBusy_nxt = r_writeBusy;
        if (w_wr_hit)   w_writeBusy_nxt[i_memWriteRespSerial] = 1'b0;
        if (w_grant_wr) w_writeBusy_nxt[w_wfree_idx] = 1'b1;
        w_out_nxt = '0;
        for (int s = 0; s < READ_SERIAL_NUM; s++) begin
            w_out_nxt = w_out_nxt + OW'(w_readBusy_nxt[s]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_readBusy         <= '0;
            r_writeBusy        <= '0;
            r_rrPtr            <= '0;
            r_readResultValid  <= '0;
            r_readResultSerial <= '0;
            r_readResultData   <= '0;
            r_writeRespValid   <= '0;
            r_writeRespSerial  <= '0;
            r_outstandingReads <= '0;
            r_protocolError    <= 1'b0;
            for (int s = 0; s < READ_SERIAL_NUM; s++)  r_readOwner[s]  <= '0;
            for (int s = 0; s < WRITE_SERIAL_NUM; s++) r_writeOwner[s] <= '0;
            for (int p = 0; p < REQ_PORT_NUM; p++)     r_portCount[p]  <= '0;
        end else begin
            if (w_grant) begin
                r_rrPtr <= (w_win == PW'(REQ_PORT_NUM - 1)) ? '0 : PW'(w_win + 1'b1);
            end
            if (w_grant_rd) r_readOwner[w_rfree_idx]  <= w_win;
            if (w_grant_wr) r_writeOwner[w_wfree_idx] <= w_win;
            r_readBusy         <= w_readBusy_nxt;
            r_writeBusy        <= w_writeBusy_nxt;
            r_outstandingReads <= w_out_nxt;
            for (int p = 0; p < REQ_PORT_NUM; p++) begin
                r_portCount[p] <= r_portCount[p]
                                + CW'(w_grant_rd && (w_win == PW'(p)))
                                - CW'(w_rd_hit && (w_rd_owner == PW'(p)));
            end
            r_readResultValid <= w_rd_hit ? (REQ_PORT_NUM'(1) << w_rd_owner) : '0;
            if (w_rd_hit) begin
                r_readResultSerial <= i_memReadSerial;
                r_readResultData   <= i_memReadData;
            end
            r_writeRespValid <= w_wr_hit ? (REQ_PORT_NUM'(1) << w_wr_owner) : '0;
            if (w_wr_hit) r_writeRespSerial <= i_memWriteRespSerial;
            if ((i_memReadValid && !w_rd_hit) || (i_memWriteRespValid && !w_wr_hit)) begin
                r_protocolError <= 1'b1;
            end
        end
    end

    // Combinational request path is forced quiet while reset is held.
    assign o_memReqValid      = w_win_vld && w_live;
    assign o_memReqWE         = o_memReqValid ? w_win_we : 1'b0;
    assign o_memReqAddr       = o_memReqValid ? i_reqAddr[w_win*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign o_memReqData       = o_memReqValid ? i_reqData[w_win*LINE_WIDTH +: LINE_WIDTH] : '0;
    assign o_memReqSerial     = w_live ? w_rfree_idx : '0;
    assign o_memReqWSerial    = w_live ? w_wfree_idx : '0;
    assign o_reqSerial        = o_memReqSerial;
    assign o_reqWSerial       = o_memReqWSerial;
    assign o_reqAck           = w_grant ? (REQ_PORT_NUM'(1) << w_win) : '0;
    assign o_readResultValid  = r_readResultValid;
    assign o_readResultSerial = r_readResultSerial;
    assign o_readResultData   = r_readResultData;
    assign o_writeRespValid   = r_writeRespValid;
    assign o_writeRespSerial  = r_writeRespSerial;
    assign o_outstandingReads = r_outstandingReads;
    assign o_protocolError    = r_protocolError;

endmodule

// File: tb/tb_mem_access_serial_arbiter.sv
// Bench for mem_access_serial_arbiter: directed table, corner sequences and a
// randomized run against a pool/owner reference model.
module tb_mem_access_serial_arbiter;

    localparam int N   = 3;
    localparam int RSN = 8;
    localparam int WSN = 4;
    localparam int LIM = 4;
    localparam int AW  = 32;
    localparam int LW  = 128;

    logic            clk, rst;
    logic [N-1:0]    reqValid, reqWE, reqAck;
    logic [N*AW-1:0] reqAddr;
    logic [N*LW-1:0] reqData;
    logic [2:0]      reqSerial, memReqSerial, memReadSerial, readResultSerial;
    logic [1:0]      reqWSerial, memReqWSerial, memWriteRespSerial, writeRespSerial;
    logic            memReqValid, memReqWE, memReqReady, memReadValid, memWriteRespValid;
    logic [AW-1:0]   memReqAddr;
    logic [LW-1:0]   memReqData, memReadData, readResultData;
    logic [N-1:0]    readResultValid, writeRespValid;
    logic [3:0]      outstandingReads;
    logic            protocolError;

    mem_access_serial_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_reqValid(reqValid), .i_reqWE(reqWE), .i_reqAddr(reqAddr), .i_reqData(reqData),
        .o_reqAck(reqAck), .o_reqSerial(reqSerial), .o_reqWSerial(reqWSerial),
        .o_memReqValid(memReqValid), .o_memReqWE(memReqWE), .o_memReqAddr(memReqAddr),
        .o_memReqData(memReqData), .o_memReqSerial(memReqSerial), .o_memReqWSerial(memReqWSerial),
        .i_memReqReady(memReqReady),
        .i_memReadValid(memReadValid), .i_memReadSerial(memReadSerial), .i_memReadData(memReadData),
        .i_memWriteRespValid(memWriteRespValid), .i_memWriteRespSerial(memWriteRespSerial),
        .o_readResultValid(readResultValid), .o_readResultSerial(readResultSerial),
        .o_readResultData(readResultData),
        .o_writeRespValid(writeRespValid), .o_writeRespSerial(writeRespSerial),
        .o_outstandingReads(outstandingReads), .o_protocolError(protocolError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: serial pools as busy/owner arrays, pointer as an int.
    bit         m_rbusy [RSN];
    int         m_rown  [RSN];
    bit         m_wbusy [WSN];
    int         m_wown  [WSN];
    int         m_rr;
    bit         m_perr;
    logic [2:0] e_rrv, e_wrv;
    int         e_rrs, e_wrs;
    logic [LW-1:0] e_rrd;
    logic [2:0] obs_ack;
    int         obs_rs, obs_ws;

    typedef struct {
        logic [2:0] v;
        logic [2:0] we;
        bit         rdy;
        bit         rdv;
        int         rds;
        logic [2:0] x_ack;
        int         x_rs;
        logic [2:0] x_rrv;
        int         x_out;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < RSN; s++) begin m_rbusy[s] = 0; m_rown[s] = 0; end
        for (int s = 0; s < WSN; s++) begin m_wbusy[s] = 0; m_wown[s] = 0; end
        m_rr = 0; m_perr = 0;
        e_rrv = '0; e_wrv = '0; e_rrs = 0; e_wrs = 0; e_rrd = '0;
    endtask

    function automatic int port_reads(input int p);
        int n = 0;
        for (int s = 0; s < RSN; s++) if (m_rbusy[s] && m_rown[s] == p) n++;
        return n;
    endfunction

    function automatic int first_free_r();
        for (int s = 0; s < RSN; s++) if (!m_rbusy[s]) return s;
        return -1;
    endfunction

    function automatic int first_free_w();
        for (int s = 0; s < WSN; s++) if (!m_wbusy[s]) return s;
        return -1;
    endfunction

    task automatic idle();
        reqValid = '0; reqWE = '0; memReqReady = 1'b0;
        memReadValid = 1'b0; memReadSerial = '0;
        memWriteRespValid = 1'b0; memWriteRespSerial = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: check everything at the negedge, then advance the model.
    task automatic cyc();
        int nb, fr, fw, win, idx;
        bit el [N];
        logic [2:0] ea;
        @(negedge clk);
        obs_ack = reqAck; obs_rs = int'(reqSerial); obs_ws = int'(reqWSerial);
        chk("rres_valid", readResultValid, e_rrv);
        if (e_rrv != 0) begin
            chk("rres_serial", readResultSerial, e_rrs);
            chk("rres_data", readResultData, e_rrd);
        end
        chk("wresp_valid", writeRespValid, e_wrv);
        if (e_wrv != 0) chk("wresp_serial", writeRespSerial, e_wrs);
        nb = 0;
        for (int s = 0; s < RSN; s++) if (m_rbusy[s]) nb++;
        chk("outstanding", outstandingReads, nb);
        chk("proto_err", protocolError, m_perr);

        fr = first_free_r(); fw = first_free_w();
        for (int p = 0; p < N; p++)
            el[p] = reqValid[p] && (reqWE[p] ? (fw >= 0) : (fr >= 0 && port_reads(p) < LIM));
        win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (win < 0 && el[idx]) win = idx;
        end
        ea = (win >= 0 && memReqReady) ? 3'(1 << win) : 3'b000;
        chk("mem_valid", memReqValid, win >= 0);
        chk("ack", reqAck, ea);
        if (win >= 0) begin
            chk("mem_we", memReqWE, reqWE[win]);
            chk("mem_addr", memReqAddr, reqAddr[win*AW +: AW]);
            chk("mem_data", memReqData, reqData[win*LW +: LW]);
            if (reqWE[win]) begin
                chk("mem_wserial", memReqWSerial, fw);
                chk("req_wserial", reqWSerial, fw);
            end else begin
                chk("mem_serial", memReqSerial, fr);
                chk("req_serial", reqSerial, fr);
            end
        end

        e_rrv = '0;
        if (memReadValid) begin
            if (m_rbusy[memReadSerial]) begin
                e_rrv = 3'(1 << m_rown[memReadSerial]);
                e_rrs = int'(memReadSerial);
                e_rrd = memReadData;
                m_rbusy[memReadSerial] = 0;
            end else m_perr = 1;
        end
        e_wrv = '0;
        if (memWriteRespValid) begin
            if (m_wbusy[memWriteRespSerial]) begin
                e_wrv = 3'(1 << m_wown[memWriteRespSerial]);
                e_wrs = int'(memWriteRespSerial);
                m_wbusy[memWriteRespSerial] = 0;
            end else m_perr = 1;
        end
        if (ea != 0) begin
            m_rr = (win + 1) % N;
            if (reqWE[win]) begin m_wbusy[fw] = 1; m_wown[fw] = win; end
            else            begin m_rbusy[fr] = 1; m_rown[fr] = win; end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt, s;
        rst = 1'b1;
        reqAddr = '0; reqData = '0; memReadData = '0;
        do_reset();

        // Directed table: three reads in round-robin order, then a result for serial 1.
        for (int p = 0; p < N; p++) begin
            reqAddr[p*AW +: AW] = 32'h1000 * (p + 1);
            reqData[p*LW +: LW] = {4{32'hC0DE0000 + p}};
        end
        memReadData = {16{8'hA5}};
        tbl[0] = '{3'b111, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 0};
        tbl[1] = '{3'b110, 3'b000, 1, 0, 0, 3'b010, 1, 3'b000, 1};
        tbl[2] = '{3'b100, 3'b000, 1, 0, 0, 3'b100, 2, 3'b000, 2};
        tbl[3] = '{3'b000, 3'b000, 1, 1, 1, 3'b000, 0, 3'b000, 3};
        tbl[4] = '{3'b001, 3'b000, 1, 0, 0, 3'b001, 1, 3'b010, 2};
        for (int i = 0; i < 5; i++) begin
            reqValid = tbl[i].v; reqWE = tbl[i].we; memReqReady = tbl[i].rdy;
            memReadValid = tbl[i].rdv; memReadSerial = 3'(tbl[i].rds);
            #2;
            chk("tbl_ack", reqAck, tbl[i].x_ack);
            if (tbl[i].x_ack != 0) chk("tbl_serial", reqSerial, tbl[i].x_rs);
            chk("tbl_rrv", readResultValid, tbl[i].x_rrv);
            chk("tbl_out", outstandingReads, tbl[i].x_out);
            cyc();
        end

        // Per-port read cap.
        do_reset();
        memReqReady = 1'b1; reqValid = 3'b001; cnt = 0;
        for (int i = 0; i < 4; i++) begin cyc(); if (obs_ack == 3'b001) cnt++; end
        chk("lim_acks", cnt, 4);
        reqValid = 3'b011;
        cyc();
        chk("lim_port1", obs_ack, 3'b010);
        reqValid = 3'b001; memReadValid = 1'b1; memReadSerial = 3'd2;
        cyc();
        chk("lim_stalled", obs_ack, 3'b000);
        memReadValid = 1'b0;
        cyc();
        chk("lim_fifth", obs_ack, 3'b001);
        chk("lim_fifth_serial", obs_rs, 2);

        // Full read pool: writes still go through.
        do_reset();
        memReqReady = 1'b1; reqValid = 3'b011;
        for (int i = 0; i < 8; i++) cyc();
        chk("full_out", outstandingReads, 8);
        reqValid = 3'b111; reqWE = 3'b100;
        cyc();
        chk("full_wr_ack", obs_ack, 3'b100);
        chk("full_wserial", obs_ws, 0);
        reqValid = 3'b011; reqWE = 3'b000;
        cyc();
        chk("full_rd_blocked", obs_ack, 3'b000);

        // Unknown serial raises a sticky error.
        do_reset();
        memReadValid = 1'b1; memReadSerial = 3'd5;
        cyc();
        memReadValid = 1'b0;
        repeat (3) cyc();
        chk("unk_no_result", readResultValid, 3'b000);
        chk("unk_sticky", protocolError, 1'b1);

        // Reset with reads in flight.
        do_reset();
        chk("rst_clears_err", protocolError, 1'b0);
        memReqReady = 1'b1; reqValid = 3'b111;
        for (int i = 0; i < 3; i++) begin cyc(); reqValid = reqValid & ~obs_ack; end
        chk("pre_rst_out", outstandingReads, 3);
        reqValid = 3'b001;
        rst = 1'b1;
        #1;
        chk("rst_memvalid", memReqValid, 1'b0);
        chk("rst_ack", reqAck, 3'b000);
        chk("rst_out", outstandingReads, 0);
        chk("rst_rrv", readResultValid, 3'b000);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        chk("post_rst_ack", obs_ack, 3'b001);
        chk("post_rst_serial", obs_rs, 0);
        reqValid = 3'b000; memReadValid = 1'b1; memReadSerial = 3'd2;
        cyc();
        memReadValid = 1'b0;
        cyc();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!reqValid[p] && $urandom_range(0, 3) == 0) begin
                    reqValid[p] = 1'b1;
                    reqWE[p] = ($urandom_range(0, 3) == 0);
                    reqAddr[p*AW +: AW] = $urandom;
                    reqData[p*LW +: LW] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            memReqReady = ($urandom_range(0, 9) < 7);
            memReadValid = 1'b0;
            s = $urandom_range(0, RSN - 1);
            if ($urandom_range(0, 1) == 0 && (m_rbusy[s] || $urandom_range(0, 199) == 0)) begin
                memReadValid = 1'b1; memReadSerial = 3'(s);
                memReadData = {$urandom, $urandom, $urandom, $urandom};
            end
            memWriteRespValid = 1'b0;
            s = $urandom_range(0, WSN - 1);
            if ($urandom_range(0, 1) == 0 && (m_wbusy[s] || $urandom_range(0, 199) == 0)) begin
                memWriteRespValid = 1'b1; memWriteRespSerial = 2'(s);
            end
            cyc();
            reqValid = reqValid & ~obs_ack;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
